// File: rtl/id_pkg.sv
// Shared decode constants, the ID/EX control bundle and the ARM condition evaluator
// used by id_stage_pipe and its register file.
package id_pkg;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_CMP = 4'b0100;
    localparam logic [3:0] EXE_TST = 4'b0110;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic [3:0] cmd;
        logic       mem_rd;
        logic       mem_wr;
        logic       wb_en;
        logic       imm;
        logic       b;
        logic       s;
    } id_ex_ctrl_t;

    // nzcv is {N, Z, C, V}; the reserved 1111 code never executes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return c;
            COND_CC: return !c;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return c && !z;
            COND_LS: return !c || z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z && (n == v);
            COND_LE: return z || (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// Register file with synchronous reset/write and two combinational read ports;
// a same-cycle write to a read index is passed straight through to that port.
module reg_file_bypass #(
    parameter int NUM_REGS   = 16,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic [WORD_WIDTH-1:0] rd_data1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [WORD_WIDTH-1:0] rd_data2
);

    logic [WORD_WIDTH-1:0] regs_reg [NUM_REGS];
    logic                  wr_hit;

    assign wr_hit = wr_en && (int'(wr_addr) < NUM_REGS);

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                regs_reg[gi] <= '0;
            end else if (wr_hit && wr_addr == ADDR_WIDTH'(gi)) begin
                regs_reg[gi] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data1 = '0;
        if (wr_hit && wr_addr == rd_addr1) begin
            rd_data1 = wr_data;
        end else if (int'(rd_addr1) < NUM_REGS) begin
            rd_data1 = regs_reg[rd_addr1];
        end
    end

    always_comb begin
        rd_data2 = '0;
        if (wr_hit && wr_addr == rd_addr2) begin
            rd_data2 = wr_data;
        end else if (int'(rd_addr2) < NUM_REGS) begin
            rd_data2 = regs_reg[rd_addr2];
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with register file, condition check, RAW/flag hazard stalls and a
// valid/ready ID/EX register. Define ID_FORWARDING_EN to stall only on load-use.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int WORD_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int NUM_REGS       = 16,
    parameter int STATUS_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WORD_WIDTH-1:0]     pc_in,
    input  logic [WORD_WIDTH-1:0]     instr_in,
    input  logic                      if_valid,
    output logic                      id_ready,
    input  logic                      flush,
    input  logic [STATUS_WIDTH-1:0]   status_reg,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_dst,
    input  logic [WORD_WIDTH-1:0]     wb_data,
    input  logic                      mem_wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] mem_dst,
    input  logic                      ex_ready,
    output logic                      ex_valid,
    output logic [WORD_WIDTH-1:0]     ex_pc,
    output logic [WORD_WIDTH-1:0]     ex_val_rn,
    output logic [WORD_WIDTH-1:0]     ex_val_rm,
    output logic [23:0]               ex_imm24,
    output logic [11:0]               ex_shift_op,
    output logic [REG_ADDR_WIDTH-1:0] ex_src1,
    output logic [REG_ADDR_WIDTH-1:0] ex_src2,
    output logic [REG_ADDR_WIDTH-1:0] ex_dst,
    output logic [3:0]                ex_cmd,
    output logic                      ex_mem_rd,
    output logic                      ex_mem_wr,
    output logic                      ex_wb_en,
    output logic                      ex_imm,
    output logic                      ex_b,
    output logic                      ex_s
`ifdef ID_FORWARDING_EN
    ,
    output logic                      fwd_src1_used,
    output logic                      fwd_src2_used
`endif
);

    logic [3:0] cond_f, opcode_f;
    logic [1:0] mode_f;
    logic       i_f, s_f, is_store, use1, use2, raw, flag_haz, capture;
    logic [REG_ADDR_WIDTH-1:0] src1, src2, dst;
    logic [WORD_WIDTH-1:0]     rd_val1, rd_val2;
    id_ex_ctrl_t               dec, ctrl;

    logic                      ex_valid_reg;
    id_ex_ctrl_t               ctrl_reg;
    logic [WORD_WIDTH-1:0]     pc_reg, val_rn_reg, val_rm_reg;
    logic [23:0]               imm24_reg;
    logic [11:0]               shift_op_reg;
    logic [REG_ADDR_WIDTH-1:0] src1_reg, src2_reg, dst_reg;

    assign cond_f   = instr_in[31:28];
    assign mode_f   = instr_in[27:26];
    assign i_f      = instr_in[25];
    assign opcode_f = instr_in[24:21];
    assign s_f      = instr_in[20];
    assign is_store = (mode_f == MODE_MEM) && !s_f;
    assign src1     = REG_ADDR_WIDTH'(instr_in[19:16]);
    assign dst      = REG_ADDR_WIDTH'(instr_in[15:12]);
    assign src2     = is_store ? dst : REG_ADDR_WIDTH'(instr_in[3:0]);

    reg_file_bypass #(
        .NUM_REGS  (NUM_REGS),
        .WORD_WIDTH(WORD_WIDTH),
        .ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wb_en),
        .wr_addr (wb_dst),
        .wr_data (wb_data),
        .rd_addr1(src1),
        .rd_data1(rd_val1),
        .rd_addr2(src2),
        .rd_data2(rd_val2)
    );

    always_comb begin
        dec = '0;
        case (mode_f)
            MODE_DP: begin
                dec.imm   = i_f;
                dec.s     = s_f;
                dec.wb_en = 1'b1;
                case (opcode_f)
                    OP_MOV:  dec.cmd = EXE_MOV;
                    OP_MVN:  dec.cmd = EXE_MVN;
                    OP_ADD:  dec.cmd = EXE_ADD;
                    OP_ADC:  dec.cmd = EXE_ADC;
                    OP_SUB:  dec.cmd = EXE_SUB;
                    OP_SBC:  dec.cmd = EXE_SBC;
                    OP_AND:  dec.cmd = EXE_AND;
                    OP_ORR:  dec.cmd = EXE_ORR;
                    OP_EOR:  dec.cmd = EXE_EOR;
                    OP_CMP: begin dec.cmd = EXE_CMP; dec.wb_en = 1'b0; end
                    OP_TST: begin dec.cmd = EXE_TST; dec.wb_en = 1'b0; end
                    default: dec.wb_en = 1'b0;
                endcase
            end
            MODE_MEM: begin
                dec.cmd    = EXE_ADD;
                dec.imm    = i_f;
                dec.mem_rd = s_f;
                dec.wb_en  = s_f;
                dec.mem_wr = !s_f;
            end
            MODE_BR: dec.b = 1'b1;
            default: ;
        endcase
    end

    // A failed condition still flows down as a valid no-op so EX sees its PC.
    always_comb begin
        ctrl = dec;
        if (!cond_pass(cond_f, status_reg[3:0])) begin
            ctrl.mem_rd = 1'b0;
            ctrl.mem_wr = 1'b0;
            ctrl.wb_en  = 1'b0;
            ctrl.b      = 1'b0;
            ctrl.s      = 1'b0;
        end
    end

    assign use1 = (mode_f != MODE_BR) && (opcode_f != OP_MOV) && (opcode_f != OP_MVN);
    assign use2 = ((mode_f == MODE_DP) && !i_f) || is_store;

`ifdef ID_FORWARDING_EN
    assign raw = ex_valid_reg && ctrl_reg.mem_rd &&
                 ((use1 && src1 == dst_reg) || (use2 && src2 == dst_reg));
`else
    assign raw = (use1 && ((ex_valid_reg && ctrl_reg.wb_en && src1 == dst_reg) ||
                           (mem_wb_en && src1 == mem_dst))) ||
                 (use2 && ((ex_valid_reg && ctrl_reg.wb_en && src2 == dst_reg) ||
                           (mem_wb_en && src2 == mem_dst)));
`endif

    assign flag_haz = (cond_f != COND_AL) && ex_valid_reg && ctrl_reg.s;
    assign id_ready = !(if_valid && (raw || flag_haz)) && (ex_ready || !ex_valid_reg);
    assign capture  = if_valid && id_ready;

    // Control bits are cleared whenever the slot empties; data fields just hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg <= 1'b0;
            ctrl_reg     <= '0;
            pc_reg       <= '0;
            val_rn_reg   <= '0;
            val_rm_reg   <= '0;
            imm24_reg    <= '0;
            shift_op_reg <= '0;
            src1_reg     <= '0;
            src2_reg     <= '0;
            dst_reg      <= '0;
        end else if (flush || (!capture && ex_ready)) begin
            ex_valid_reg <= 1'b0;
            ctrl_reg     <= '0;
        end else if (capture) begin
            ex_valid_reg <= 1'b1;
            ctrl_reg     <= ctrl;
            pc_reg       <= pc_in;
            val_rn_reg   <= rd_val1;
            val_rm_reg   <= rd_val2;
            imm24_reg    <= instr_in[23:0];
            shift_op_reg <= instr_in[11:0];
            src1_reg     <= src1;
            src2_reg     <= src2;
            dst_reg      <= dst;
        end
    end

`ifdef ID_FORWARDING_EN
    logic fwd1_reg, fwd2_reg;
    always_ff @(posedge clk) begin
        if (rst || flush || (!capture && ex_ready)) begin
            fwd1_reg <= 1'b0;
            fwd2_reg <= 1'b0;
        end else if (capture) begin
            fwd1_reg <= use1;
            fwd2_reg <= use2;
        end
    end
    assign fwd_src1_used = fwd1_reg;
    assign fwd_src2_used = fwd2_reg;
`endif

    assign ex_valid    = ex_valid_reg;
    assign ex_pc       = pc_reg;
    assign ex_val_rn   = val_rn_reg;
    assign ex_val_rm   = val_rm_reg;
    assign ex_imm24    = imm24_reg;
    assign ex_shift_op = shift_op_reg;
    assign ex_src1     = src1_reg;
    assign ex_src2     = src2_reg;
    assign ex_dst      = dst_reg;
    assign ex_cmd      = ctrl_reg.cmd;
    assign ex_mem_rd   = ctrl_reg.mem_rd;
    assign ex_mem_wr   = ctrl_reg.mem_wr;
    assign ex_wb_en    = ctrl_reg.wb_en;
    assign ex_imm      = ctrl_reg.imm;
    assign ex_b        = ctrl_reg.b;
    assign ex_s        = ctrl_reg.s;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed decode table, hand-written hazard /
// stall / flush sequences, then random traffic against a reference model.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0, instr_in = '0, wb_data = '0;
    logic        if_valid = 1'b0, flush = 1'b0, wb_en = 1'b0, mem_wb_en = 1'b0, ex_ready = 1'b1;
    logic [3:0]  status_reg = '0, wb_dst = '0, mem_dst = '0;
    logic        id_ready, ex_valid, ex_mem_rd, ex_mem_wr, ex_wb_en, ex_imm, ex_b, ex_s;
    logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
    logic [23:0] ex_imm24;
    logic [11:0] ex_shift_op;
    logic [3:0]  ex_src1, ex_src2, ex_dst, ex_cmd;
`ifdef ID_FORWARDING_EN
    logic        fwd_src1_used, fwd_src2_used;
`endif

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .if_valid(if_valid),
        .id_ready(id_ready), .flush(flush), .status_reg(status_reg), .wb_en(wb_en),
        .wb_dst(wb_dst), .wb_data(wb_data), .mem_wb_en(mem_wb_en), .mem_dst(mem_dst),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_val_rn(ex_val_rn),
        .ex_val_rm(ex_val_rm), .ex_imm24(ex_imm24), .ex_shift_op(ex_shift_op),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dst(ex_dst), .ex_cmd(ex_cmd),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_wb_en(ex_wb_en), .ex_imm(ex_imm),
        .ex_b(ex_b), .ex_s(ex_s)
`ifdef ID_FORWARDING_EN
        , .fwd_src1_used(fwd_src1_used), .fwd_src2_used(fwd_src2_used)
`endif
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rn, rm;
        logic [23:0] imm24;
        logic [11:0] sh;
        logic [3:0]  s1, s2, dst, cmd;
        logic        mem_rd, mem_wr, wb_en, imm, b, s, fwd1, fwd2;
    } exo_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [3:0]  nzcv;
        logic [3:0]  cmd;
        logic        wb, rd, wr, b, s;
        logic [3:0]  src2;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    exo_t        m_ex = '0;
    logic [31:0] m_regs [16];
    logic        last_rdy;

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dp(int cond, int i, int op, int s, int rn, int rd, int op2);
        return {cond[3:0], 2'b00, i[0], op[3:0], s[0], rn[3:0], rd[3:0], op2[11:0]};
    endfunction
    function automatic logic [31:0] mem(int cond, int ld, int rn, int rd, int off);
        return {cond[3:0], 2'b01, 1'b0, 4'b1100, ld[0], rn[3:0], rd[3:0], off[11:0]};
    endfunction
    function automatic logic [31:0] br(int cond, int off);
        return {cond[3:0], 2'b10, 2'b10, off[23:0]};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic cond_ok(logic [3:0] cond, logic [3:0] f);
        bit n = f[3], z = f[2], c = f[1], v = f[0];
        bit table_ok [16];
        table_ok = '{z, !z, c, !c, n, !n, v, !v, c && !z, !c || z, n == v, n != v,
                     !z && n == v, z || n != v, 1'b1, 1'b0};
        return table_ok[cond];
    endfunction

    function automatic logic [3:0] src2_of(logic [31:0] ins);
        return (ins[27:26] == 2'b01 && !ins[20]) ? ins[15:12] : ins[3:0];
    endfunction

    function automatic logic [31:0] rf_read(logic [3:0] idx);
        return (wb_en && wb_dst == idx) ? wb_data : m_regs[idx];
    endfunction

    function automatic exo_t model_decode(logic [31:0] ins, logic [3:0] nzcv, logic [31:0] pc);
        // Opcode -> command; 0 marks opcodes this subset does not execute.
        int   dp_cmd [16] = '{6, 8, 4, 0, 2, 3, 5, 0, 6, 0, 4, 0, 7, 1, 0, 9};
        int   mode = int'(ins[27:26]);
        int   op   = int'(ins[24:21]);
        exo_t e    = '0;
        e.valid = 1'b1;  e.pc = pc;  e.imm24 = ins[23:0];  e.sh = ins[11:0];
        e.s1 = ins[19:16];  e.dst = ins[15:12];  e.s2 = src2_of(ins);
        e.rn = rf_read(e.s1);  e.rm = rf_read(e.s2);
        if (mode == 0) begin
            e.cmd = 4'(dp_cmd[op]);
            e.imm = ins[25];  e.s = ins[20];
            e.wb_en = dp_cmd[op] != 0 && op != 8 && op != 10;
        end else if (mode == 1) begin
            e.cmd = 4'd2;  e.imm = ins[25];
            e.mem_rd = ins[20];  e.wb_en = ins[20];  e.mem_wr = !ins[20];
        end else if (mode == 2) begin
            e.b = 1'b1;
        end
`ifdef ID_FORWARDING_EN
        e.fwd1 = mode != 2 && op != 13 && op != 15;
        e.fwd2 = (mode == 0 && !ins[25]) || (mode == 1 && !ins[20]);
`endif
        if (!cond_ok(ins[31:28], nzcv)) {e.mem_rd, e.mem_wr, e.wb_en, e.b, e.s} = '0;
        return e;
    endfunction

    function automatic logic model_ready();
        logic [31:0] ins = instr_in;
        bit   use1 = ins[27:26] != 2'b10 && ins[24:21] != 4'd13 && ins[24:21] != 4'd15;
        bit   use2 = (ins[27:26] == 2'b00 && !ins[25]) || (ins[27:26] == 2'b01 && !ins[20]);
        logic [3:0] writers [$];
        bit   raw = 0, flg;
`ifdef ID_FORWARDING_EN
        if (m_ex.valid && m_ex.mem_rd) writers.push_back(m_ex.dst);
`else
        if (m_ex.valid && m_ex.wb_en) writers.push_back(m_ex.dst);
        if (mem_wb_en) writers.push_back(mem_dst);
`endif
        foreach (writers[k])
            if ((use1 && writers[k] == ins[19:16]) || (use2 && writers[k] == src2_of(ins))) raw = 1;
        flg = ins[31:28] != 4'hE && m_ex.valid && m_ex.s;
        return !(if_valid && (raw || flg)) && (ex_ready || !m_ex.valid);
    endfunction

    function automatic exo_t emptied(exo_t e);
        exo_t r = e;
        r.valid = 0;  r.cmd = '0;
        {r.mem_rd, r.mem_wr, r.wb_en, r.imm, r.b, r.s, r.fwd1, r.fwd2} = '0;
        return r;
    endfunction

    function automatic exo_t dut_out();
        exo_t o;
        o = {ex_valid, ex_pc, ex_val_rn, ex_val_rm, ex_imm24, ex_shift_op, ex_src1, ex_src2,
             ex_dst, ex_cmd, ex_mem_rd, ex_mem_wr, ex_wb_en, ex_imm, ex_b, ex_s, 2'b00};
`ifdef ID_FORWARDING_EN
        o.fwd1 = fwd_src1_used;  o.fwd2 = fwd_src2_used;
`endif
        return o;
    endfunction

    // One clock: check id_ready, predict the next ID/EX contents, check after the edge.
    task automatic step();
        exo_t nxt;
        #1;
        last_rdy = model_ready();
        chk("id_ready", id_ready, last_rdy);
        if (rst)                       nxt = '0;
        else if (flush)                nxt = emptied(m_ex);
        else if (if_valid && last_rdy) nxt = model_decode(instr_in, status_reg, pc_in);
        else if (ex_ready)             nxt = emptied(m_ex);
        else                           nxt = m_ex;
        @(posedge clk);
        m_ex = nxt;
        if (rst) foreach (m_regs[k]) m_regs[k] = '0;
        else if (wb_en) m_regs[wb_dst] = wb_data;
        #1;
        chk("ex_bundle", dut_out(), m_ex);
    endtask

    task automatic idle();
        if_valid = 0;  flush = 0;  wb_en = 0;  mem_wb_en = 0;  ex_ready = 1;  rst = 0;
    endtask

    task automatic issue(logic [31:0] ins, logic [31:0] pc);
        instr_in = ins;  pc_in = pc;  if_valid = 1;
    endtask

    // Holds an instruction in ID until accepted; returns the number of stall cycles.
    task automatic count_stalls(output int stalls, output bit got, input int mem_cycle);
        stalls = 0;  got = 0;
        for (int k = 1; k <= 8 && !got; k++) begin
            mem_wb_en = (k == mem_cycle);
            step();
            if (last_rdy) got = 1;
            else stalls++;
        end
        mem_wb_en = 0;
        if_valid  = 0;
    endtask

    initial begin
        vec_t vt [$];
        exo_t snap;
        int   stalls, exp_ld;
        bit   got;

        foreach (m_regs[k]) m_regs[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_bundle", dut_out(), '0);
        rst = 0;
        step();

        // ADD R1,R2,R3 with R2=5, R3=7
        wb_en = 1;  wb_dst = 2;  wb_data = 5;  step();
        wb_dst = 3;  wb_data = 7;  step();
        wb_en = 0;
        issue(dp(14, 0, 4, 0, 2, 1, 3), 32'h100);  step();  if_valid = 0;
        chk("add_valid", ex_valid, 1);
        chk("add_rn", ex_val_rn, 5);
        chk("add_rm", ex_val_rm, 7);
        chk("add_wb", ex_wb_en, 1);
        chk("add_cmd", ex_cmd, 4'b0010);
        $display("seq add: rn=%0d rm=%0d", ex_val_rn, ex_val_rm);

        // SUB R5,R4,#1 while R4=0x11 is written back the same cycle
        wb_en = 1;  wb_dst = 4;  wb_data = 32'h11;
        issue(dp(14, 1, 2, 0, 4, 5, 1), 32'h104);  step();
        idle();
        chk("bypass_rn", ex_val_rn, 32'h11);
        $display("seq bypass: rn=%0h", ex_val_rn);
        step();

        // LDR R1 in EX, then ADD R2,R1,R1; LDR reaches MEM on the second ADD cycle
`ifdef ID_FORWARDING_EN
        exp_ld = 1;
`else
        exp_ld = 2;
`endif
        mem_dst = 1;
        issue(mem(14, 1, 0, 1, 0), 32'h200);  step();
        issue(dp(14, 0, 4, 0, 1, 2, 1), 32'h204);
        count_stalls(stalls, got, 2);
        chk("load_use_accepted", got, 1);
        chk("load_use_stalls", stalls, exp_ld);
        $display("seq load-use: stalls=%0d", stalls);
        step();

        // CMP R1,R2 (S=1), then ADDEQ with Z=0
        status_reg = 4'b0000;
        issue(dp(14, 0, 10, 1, 1, 0, 2), 32'h300);  step();
        issue(dp(0, 0, 4, 0, 4, 3, 5), 32'h304);
        count_stalls(stalls, got, 0);
        chk("flag_accepted", got, 1);
        chk("flag_stalls", stalls, 1);
        chk("addeq_valid", ex_valid, 1);
        chk("addeq_wb", ex_wb_en, 0);
        $display("seq flag: stalls=%0d wb=%0b", stalls, ex_wb_en);
        step();

        // EX back-pressure for three cycles, then a flush while still blocked
        issue(dp(14, 0, 4, 0, 7, 6, 8), 32'h400);  step();
        snap = m_ex;
        ex_ready = 0;
        issue(dp(14, 0, 4, 0, 9, 10, 11), 32'h404);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_hold", dut_out(), snap);
            chk("stall_ready", id_ready, 0);
        end
        flush = 1;  step();
        chk("flush_valid", ex_valid, 0);
        chk("flush_ctrl", {ex_cmd, ex_mem_rd, ex_mem_wr, ex_wb_en, ex_imm, ex_b, ex_s}, '0);
        $display("seq stall+flush: valid=%0b", ex_valid);
        idle();
        step();

        // Decode / condition table
        vt.push_back('{"add",    dp(14,0,4,0,2,1,3),   4'b0000, 4'd2, 1,0,0,0,0, 4'd3});
        vt.push_back('{"subs",   dp(14,0,2,1,2,1,3),   4'b0000, 4'd4, 1,0,0,0,1, 4'd3});
        vt.push_back('{"cmp",    dp(14,0,10,1,1,0,2),  4'b0000, 4'd4, 0,0,0,0,1, 4'd2});
        vt.push_back('{"tst",    dp(14,0,8,1,1,0,2),   4'b0000, 4'd6, 0,0,0,0,1, 4'd2});
        vt.push_back('{"mov",    dp(14,1,13,0,0,1,'ha5), 4'b0000, 4'd1, 1,0,0,0,0, 4'd5});
        vt.push_back('{"mvn",    dp(14,0,15,0,0,1,4),  4'b0000, 4'd9, 1,0,0,0,0, 4'd4});
        vt.push_back('{"and",    dp(14,0,0,0,2,1,3),   4'b0000, 4'd6, 1,0,0,0,0, 4'd3});
        vt.push_back('{"eor",    dp(14,0,1,0,2,1,3),   4'b0000, 4'd8, 1,0,0,0,0, 4'd3});
        vt.push_back('{"orr",    dp(14,0,12,0,2,1,3),  4'b0000, 4'd7, 1,0,0,0,0, 4'd3});
        vt.push_back('{"adc",    dp(14,0,5,0,2,1,3),   4'b0000, 4'd3, 1,0,0,0,0, 4'd3});
        vt.push_back('{"sbc",    dp(14,0,6,0,2,1,3),   4'b0000, 4'd5, 1,0,0,0,0, 4'd3});
        vt.push_back('{"ldr",    mem(14,1,2,3,4),      4'b0000, 4'd2, 1,1,0,0,0, 4'd4});
        vt.push_back('{"str",    mem(14,0,2,3,4),      4'b0000, 4'd2, 0,0,1,0,0, 4'd3});
        vt.push_back('{"b",      br(14,'h10),          4'b0000, 4'd0, 0,0,0,1,0, 4'd0});
        vt.push_back('{"addeq0", dp(0,0,4,0,2,1,3),    4'b0000, 4'd2, 0,0,0,0,0, 4'd3});
        vt.push_back('{"addeq1", dp(0,0,4,0,2,1,3),    4'b0100, 4'd2, 1,0,0,0,0, 4'd3});
        vt.push_back('{"bne_z",  br(1,'h10),           4'b0100, 4'd0, 0,0,0,0,0, 4'd0});
        vt.push_back('{"addsgt", dp(12,0,4,1,2,1,3),   4'b1001, 4'd2, 1,0,0,0,1, 4'd3});
        vt.push_back('{"addslt", dp(11,0,4,1,2,1,3),   4'b1000, 4'd2, 1,0,0,0,1, 4'd3});
        vt.push_back('{"addshi", dp(8,0,4,1,2,1,3),    4'b0110, 4'd2, 0,0,0,0,0, 4'd3});
        vt.push_back('{"ldrcs",  mem(2,1,2,3,4),       4'b0000, 4'd2, 0,0,0,0,0, 4'd4});
        foreach (vt[k]) begin
            idle();  step();
            status_reg = vt[k].nzcv;
            issue(vt[k].ins, 32'h1000 + 32'(k * 4));
            step();
            if_valid = 0;
            chk(vt[k].name, {ex_valid, ex_cmd, ex_wb_en, ex_mem_rd, ex_mem_wr, ex_b, ex_s, ex_src2},
                {1'b1, vt[k].cmd, vt[k].wb, vt[k].rd, vt[k].wr, vt[k].b, vt[k].s, vt[k].src2});
            $display("vec %-7s instr=%h cmd=%h wb=%0b rd=%0b wr=%0b b=%0b s=%0b", vt[k].name,
                     vt[k].ins, ex_cmd, ex_wb_en, ex_mem_rd, ex_mem_wr, ex_b, ex_s);
        end

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            int          sel;
            rst        = $urandom_range(0, 99) == 0;
            flush      = $urandom_range(0, 19) == 0;
            if_valid   = $urandom_range(0, 9) < 8;
            ex_ready   = $urandom_range(0, 3) != 0;
            status_reg = 4'($urandom);
            wb_en      = 1'($urandom);
            wb_dst     = 4'($urandom_range(0, 5));
            wb_data    = $urandom;
            mem_wb_en  = 1'($urandom);
            mem_dst    = 4'($urandom_range(0, 3));
            pc_in      = $urandom;
            ins        = $urandom;
            sel        = $urandom_range(0, 9);
            ins[27:26] = sel < 6 ? 2'b00 : (sel < 9 ? 2'b01 : 2'b10);
            ins[31:28] = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'hE;
            if (sel < 9) begin
                ins[19:16] = 4'($urandom_range(0, 3));
                ins[15:12] = 4'($urandom_range(0, 3));
                ins[3:0]   = 4'($urandom_range(0, 3));
            end
            instr_in = ins;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised next-generation decode stage for the ARM-subset pipeline.
- Contains the following:
  - an internal register file with write-through bypass;
  - a control decoder;
  - a condition check;
  - RAW and flag hazard detection;
  - the registered ID/EX boundary.
- Uses a valid/ready handshake instead of a plain freeze.
- Sits between the IF/ID register and the EX stage.

Parameters:
- WORD_WIDTH, 32, datapath/instruction width.
- REG_ADDR_WIDTH, 4, register index width.
- NUM_REGS, 16, register count; must be ≤ 2**REG_ADDR_WIDTH.
- STATUS_WIDTH, 4, NZCV width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pc_in  in  WORD_WIDTH  PC of the instruction in ID
- instr_in  in  WORD_WIDTH  instruction in ID
- if_valid  in  1  instr_in is valid
- id_ready  out  1  ID accepts instr_in this cycle
- flush  in  1  branch taken in EX; kill the ID/EX contents
- status_reg  in  STATUS_WIDTH  committed NZCV
- wb_en  in  1  writeback enable
- wb_dst  in  REG_ADDR_WIDTH  writeback index
- wb_data  in  WORD_WIDTH  writeback value
- mem_wb_en  in  1  instruction in MEM writes a register
- mem_dst  in  REG_ADDR_WIDTH  MEM-stage destination
- ex_ready  in  1  EX accepts the ID/EX contents
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_pc, ex_val_rn, ex_val_rm  out  WORD_WIDTH  registered PC and operands
- ex_imm24  out  24  signed immediate
- ex_shift_op  out  12  shifter operand
- ex_src1, ex_src2, ex_dst  out  REG_ADDR_WIDTH  registered register indices
- ex_cmd  out  4  execute command
- ex_mem_rd, ex_mem_wr, ex_wb_en, ex_imm, ex_b, ex_s  out  1  registered control bits

Behaviour:
- Instruction fields:
  - cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], shifter[11:0], imm24[23:0].
  - src1 = Rn.
  - src2 = Rd when the instruction is a store, otherwise instr[3:0].
- Decoder:
  - mode 00: data processing; opcode maps to EXE_* constants.
  - mode 01: S=1 is LDR, S=0 is STR; both use EXE_ADD.
  - mode 10: branch.
  - CMP/TST never set wb_en.
  - ex_s is the S bit for data processing, 0 otherwise.
- Condition check:
  - Evaluates cond against status_reg using the standard ARM table.
  - When the condition fails, the instruction still advances with ex_valid=1, but mem_rd, mem_wr, wb_en, b and s are forced to 0.
- Register file:
  - Written synchronously on wb_en.
  - Reads are combinational.
  - When wb_en is set and wb_dst equals a source index, the read returns wb_data in the same cycle.
  - Reset clears all entries to 0.
- Source usage:
  - use1 = mode≠10 and opcode∉{MOV,MVN}.
  - use2 = (mode==00 and !I) or store.
- RAW hazard is asserted when a used source equals either:
  - ex_dst, with ex_valid & ex_wb_en; or
  - mem_dst, with mem_wb_en.
- Flag hazard is asserted when cond≠AL (1110) and ex_valid & ex_s. The stall lasts until that instruction leaves EX.
- Handshake:
  - hazard = if_valid & (raw | flag).
  - id_ready = ~hazard & (ex_ready | ~ex_valid).
  - Capture when if_valid & id_ready.
  - When ex_ready is set and nothing is captured, ex_valid←0 (bubble).
  - While ex_valid & ~ex_ready, all ex_* outputs hold stable.
- flush:
  - Has priority over capture and over hold.
  - Next cycle ex_valid=0 and ex_* control bits are 0.
  - The ID instruction is dropped that cycle (id_ready may be 1; upstream discards it).
- Latency: one cycle from capture to ex_*.
- Reset:
  - Synchronous, active-high.
  - All ex_* outputs are 0 and ex_valid=0.
  - rst takes effect mid-stall or mid-flush identically.

Optional Feature:
- Macro: ID_FORWARDING_EN.
- Defined:
  - A RAW stall is raised only when ex_valid & ex_mem_rd matches a used source (load-use, one bubble).
  - MEM-stage matches are ignored; the forwarding unit resolves them.
  - Outputs fwd_src1_used and fwd_src2_used (1 bit each, registered with ID/EX) mark which sources the instruction reads.
- Undefined:
  - Full RAW stalling against both EX and MEM.
  - fwd_* ports are absent.

Decomposition:
- Package id_pkg holds:
  - MODE_* constants;
  - EXE_* command codes;
  - opcode constants (MOV, MVN, CMP, TST, …);
  - COND_* codes;
  - a struct for the ID/EX control bundle.
- Sub-module reg_file_bypass (NUM_REGS, WORD_WIDTH) contains the register file and its write-through logic.

Test Plan:
- Reset, then ADD R1,R2,R3 with R2=5, R3=7 → next cycle ex_valid=1, ex_val_rn=5, ex_val_rm=7, ex_wb_en=1, ex_cmd=EXE_ADD.
- Writeback of R4=0x11 in the same cycle as decoding SUB R5,R4,#1 → ex_val_rn=0x11 (bypass).
- LDR R1 in EX, then ADD R2,R1,R1 in ID:
  - Without the macro: id_ready=0 for 2 cycles (EX match, then MEM match).
  - With ID_FORWARDING_EN: id_ready=0 for 1 cycle.
- CMP R1,R2 with S=1 in EX, then ADDEQ in ID → one stall cycle. With status_reg Z=0, ADDEQ reaches ex_* with wb_en=0.
- ex_ready=0 for 3 cycles with ex_valid=1 → ex_* remain unchanged and id_ready=0.
- flush asserted while ex_ready=0 → next cycle ex_valid=0, all control bits 0.
